mdio_master: RTL and testbench

- MAC-side MDIO management controller.
- Accepts single register read/write requests on a Wishbone-style slave port and serialises each one into a Clause 22 MDIO frame: preamble, ST, OP, PHYAD, REGAD, TA, DATA.
- Generates MDC by dividing the system clock, drives MDIO through a separate output-enable, and samples read data from the PHY.
- Sits between the management CPU/register bus and the external PHY pins (tristate buffer outside this block).

---
 rtl/mdio_master_pkg.sv | 58 +++++
 rtl/mdio_master_mdc_gen.sv | 40 ++++
 rtl/mdio_master.sv | 168 ++++++++++++++++
 tb/tb_mdio_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_master_pkg.sv
// Shared MDIO Clause 22 definitions: opcodes, field widths, FSM states and
// field sequencing helpers used by the MAC-side master.
package mdio_master_pkg;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int PHYAD_BITS = 5;
    localparam int REGAD_BITS = 5;
    localparam int TA_BITS    = 2;
    localparam int DATA_BITS  = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_DONE
    } mdio_state_e;

    // Field order on the wire; DATA is followed by the completion cycle.
    function automatic mdio_state_e next_field(input mdio_state_e s);
        mdio_state_e n;
        case (s)
            S_PRE:   n = S_ST;
            S_ST:    n = S_OP;
            S_OP:    n = S_PHYAD;
            S_PHYAD: n = S_REGAD;
            S_REGAD: n = S_TA;
            S_TA:    n = S_DATA;
            S_DATA:  n = S_DONE;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    // Bit counter reload value (index of the first, most significant bit).
    function automatic logic [4:0] field_msb(input mdio_state_e s, input int pre_bits);
        logic [4:0] m;
        case (s)
            S_PRE:      m = 5'(pre_bits - 1);
            S_ST, S_OP: m = 5'd1;
            S_PHYAD:    m = 5'(PHYAD_BITS - 1);
            S_REGAD:    m = 5'(REGAD_BITS - 1);
            S_TA:       m = 5'(TA_BITS - 1);
            S_DATA:     m = 5'(DATA_BITS - 1);
            default:    m = 5'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mdio_master_mdc_gen.sv
// MDC divider: DIV system clocks per half-period, low half first after clear.
// rise_tick_o/fall_tick_o flag the last cycle before MDC goes high/low.
module mdio_mdc_gen #(
    parameter int DIV = 25
) (
    input  logic clk,
    input  logic clear_i,
    input  logic en_i,
    output logic mdc_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam logic [7:0] RELOAD = 8'(DIV - 1);

    logic [7:0] cnt_q;
    logic       mdc_q;
    logic       terminal;

    assign terminal    = en_i && (cnt_q == 8'd0);
    assign rise_tick_o = terminal && !mdc_q;
    assign fall_tick_o = terminal && mdc_q;
    assign mdc_o       = mdc_q;

    // Half-period counter; clear restarts a full low half-period.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            cnt_q <= RELOAD;
            mdc_q <= 1'b0;
        end else if (en_i) begin
            if (cnt_q == 8'd0) begin
                cnt_q <= RELOAD;
                mdc_q <= ~mdc_q;
            end else begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

endmodule

// File: rtl/mdio_master.sv
// MAC-side MDIO master: turns one bus request into a Clause 22 frame,
// drives MDIO with a separate enable and captures read data from the PHY.
module mdio_master
    import mdio_master_pkg::*;
#(
    parameter int DIV           = 25,
    parameter int PREAMBLE_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [4:0]  phyad,
    input  logic [4:0]  addr,
    input  logic [15:0] data_write,
    output logic        ack,
    output logic        err,
    output logic [15:0] data_read,
    output logic        mdc,
    output logic        mdo,
    output logic        mdo_valid,
    input  logic        mdi
);

    mdio_state_e state_q, state_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        live_q, live_d;
    logic        taerr_q, taerr_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mdo_q, mdo_d;
    logic        oe_q, oe_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic        we_q;
    logic [4:0]  phyad_q;
    logic [4:0]  addr_q;
    logic [15:0] wdata_q;
    logic [1:0]  op_q;

    logic req, start, busy, rise_tick, fall_tick;

    assign req  = cyc && stb;
    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign op_q = we_q ? OP_WRITE : OP_READ;

    mdio_mdc_gen #(.DIV(DIV)) u_mdc (
        .clk         (clk),
        .clear_i     (rst || start),
        .en_i        (busy),
        .mdc_o       (mdc),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    // Frame sequencing: field/bit advance on MDC fall, mdi capture on MDC rise.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        live_d   = live_q;
        taerr_d  = taerr_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    start    = 1'b1;
                    live_d   = 1'b1;
                    taerr_d  = 1'b0;
                    state_d  = (PREAMBLE_BITS > 0) ? S_PRE : S_ST;
                    bitcnt_d = field_msb(state_d, PREAMBLE_BITS);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                // A requester that lets go mid-frame gets no completion pulse.
                if (!req) live_d = 1'b0;
                if (rise_tick && !we_q) begin
                    if (state_q == S_TA && bitcnt_q == 5'd0) taerr_d = mdi;
                    if (state_q == S_DATA) rx_d = {rx_q[14:0], mdi};
                end
                if (fall_tick) begin
                    if (bitcnt_q != 5'd0) begin
                        bitcnt_d = bitcnt_q - 5'd1;
                    end else begin
                        state_d  = next_field(state_q);
                        bitcnt_d = field_msb(state_d, PREAMBLE_BITS);
                        if (state_q == S_DATA && live_d) begin
                            err_d = !we_q && taerr_q;
                            ack_d = we_q || !taerr_q;
                            if (!we_q) rdata_d = rx_q;
                        end
                    end
                end
            end
        endcase
    end

    // Pin values for the bit about to be on the wire; reads release at TA.
    always_comb begin
        mdo_d = 1'b1;
        oe_d  = 1'b0;
        case (state_d)
            S_PRE:   oe_d = 1'b1;
            S_ST:    begin oe_d = 1'b1; mdo_d = ST_CODE[bitcnt_d[0]]; end
            S_OP:    begin oe_d = 1'b1; mdo_d = op_q[bitcnt_d[0]]; end
            S_PHYAD: begin oe_d = 1'b1; mdo_d = phyad_q[bitcnt_d[2:0]]; end
            S_REGAD: begin oe_d = 1'b1; mdo_d = addr_q[bitcnt_d[2:0]]; end
            S_TA:    begin oe_d = we_q; mdo_d = we_q ? TA_WRITE[bitcnt_d[0]] : 1'b1; end
            S_DATA:  begin oe_d = we_q; mdo_d = we_q ? wdata_q[bitcnt_d[3:0]] : 1'b1; end
            default: ;
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bitcnt_q <= 5'd0;
            live_q   <= 1'b0;
            taerr_q  <= 1'b0;
            rx_q     <= 16'h0;
            rdata_q  <= 16'h0;
            mdo_q    <= 1'b1;
            oe_q     <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            live_q   <= live_d;
            taerr_q  <= taerr_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            mdo_q    <= mdo_d;
            oe_q     <= oe_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    // Request fields are captured once at acceptance and frozen for the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            phyad_q <= 5'd0;
            addr_q  <= 5'd0;
            wdata_q <= 16'h0;
        end else if (start) begin
            we_q    <= we;
            phyad_q <= phyad;
            addr_q  <= addr;
            wdata_q <= data_write;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign data_read = rdata_q;
    assign mdo       = mdo_q;
    assign mdo_valid = oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: unit 0 (DIV=2, 32-bit preamble) and unit 1 (DIV=1,
// no preamble), each with a behavioural PHY that decodes the wire frame.
module tb_mdio_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_r, cyc_r, stb_r, we_r;
    logic [1:0][4:0]  phy_r, adr_r;
    logic [1:0][15:0] dw_r, rd_o;
    logic [1:0]       ack_o, err_o, mdc_o, mdo_o, mdo_valid_o;
    logic [1:0]       mdi_r = 2'b11;

    bit   [1:0]       phy_pres;
    logic [1:0][15:0] phy_dat;

    int          cap_n    [2] = '{0, 0};
    logic [63:0] cap_bits [2] = '{64'h0, 64'h0};
    logic [63:0] cap_oe   [2] = '{64'h0, 64'h0};
    int          ack_n    [2] = '{0, 0};
    int          err_n    [2] = '{0, 0};
    logic [1:0]  pv_oe = 2'b00, pv_mdc = 2'b00;

    int E = 0;
    int n_vec = 0, n_err = 0;

    for (genvar g = 0; g < 2; g++) begin : g_u
        mdio_master #(.DIV(g == 0 ? 2 : 1), .PREAMBLE_BITS(g == 0 ? 32 : 0)) u_dut (
            .clk        (clk),
            .rst        (rst_r[g]),
            .cyc        (cyc_r[g]),
            .stb        (stb_r[g]),
            .we         (we_r[g]),
            .phyad      (phy_r[g]),
            .addr       (adr_r[g]),
            .data_write (dw_r[g]),
            .ack        (ack_o[g]),
            .err        (err_o[g]),
            .data_read  (rd_o[g]),
            .mdc        (mdc_o[g]),
            .mdo        (mdo_o[g]),
            .mdo_valid  (mdo_valid_o[g]),
            .mdi        (mdi_r[g])
        );
    end

    always @(posedge clk) E <= E + 1;

    // PHY reply for the bit with wire index n, given n captured bits so far.
    function automatic logic phy_bit(input int pre, input int n, input logic [63:0] cb,
                                     input bit pres, input logic [15:0] d);
        int j;
        j = n - pre;
        if (j < 15 || j > 31 || !pres) return 1'b1;
        if (!(cb[n - 1 - pre - 2] && !cb[n - 1 - pre - 3])) return 1'b1;
        if (j == 15) return 1'b0;
        return d[31 - j];
    endfunction

    // Wire monitor + PHY: frames start when the enable rises, bits taken on MDC rise.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            pv_oe[g]  <= mdo_valid_o[g];
            pv_mdc[g] <= mdc_o[g];
            if (ack_o[g] === 1'b1) ack_n[g] <= ack_n[g] + 1;
            if (err_o[g] === 1'b1) err_n[g] <= err_n[g] + 1;
            if (mdo_valid_o[g] === 1'b1 && !pv_oe[g]) begin
                cap_n[g]    <= 0;
                cap_bits[g] <= 64'h0;
                cap_oe[g]   <= 64'h0;
                mdi_r[g]    <= 1'b1;
            end else if (mdc_o[g] === 1'b1 && !pv_mdc[g]) begin
                cap_n[g]    <= cap_n[g] + 1;
                cap_bits[g] <= {cap_bits[g][62:0], mdo_o[g]};
                cap_oe[g]   <= {cap_oe[g][62:0], mdo_valid_o[g]};
                mdi_r[g]    <= phy_bit(g == 0 ? 32 : 0, cap_n[g] + 1,
                                       {cap_bits[g][62:0], mdo_o[g]}, phy_pres[g], phy_dat[g]);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected wire bits and drive-enable, oldest bit most significant.
    function automatic void exp_frame(input int pre, input bit w, input logic [4:0] ph,
                                      input logic [4:0] ad, input logic [15:0] wd,
                                      output logic [63:0] b, output logic [63:0] oe);
        logic [31:0] tail, tail_oe;
        logic [63:0] ones;
        tail    = {2'b01, (w ? 2'b01 : 2'b10), ph, ad, (w ? 2'b10 : 2'b11), (w ? wd : 16'hFFFF)};
        tail_oe = w ? 32'hFFFF_FFFF : 32'hFFFC_0000;
        ones    = ((64'd1 << pre) - 64'd1) << 32;
        b       = ones | {32'h0, tail};
        oe      = ones | {32'h0, tail_oe};
    endfunction

    task automatic wait_done(input int u, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (ack_o[u] || err_o[u]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bits(input int u, input int nb, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (cap_n[u] >= nb) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // One request; with keep=1 stb stays high and we return in the completion cycle.
    task automatic xfer(input int u, input bit w, input logic [4:0] ph, input logic [4:0] ad,
                        input logic [15:0] wd, input bit pres, input logic [15:0] pd, input bit keep);
        int pre, div, a0, na, ne;
        bit ok;
        logic [63:0] eb, eo;
        pre = (u == 0) ? 32 : 0;
        div = (u == 0) ? 2 : 1;
        phy_pres[u] = pres;
        phy_dat[u]  = pd;
        na = ack_n[u];
        ne = err_n[u];
        we_r[u] = w; phy_r[u] = ph; adr_r[u] = ad; dw_r[u] = wd;
        cyc_r[u] = 1'b1;
        stb_r[u] = 1'b1;
        a0 = E + 1;
        wait_done(u, 4 * div * (pre + 32) + 20, ok);
        chk("done_seen", 64'(ok), 64'd1);
        chk("latency", 64'(E - a0 + 1), 64'(1 + 2 * div * (pre + 32)));
        exp_frame(pre, w, ph, ad, wd, eb, eo);
        chk("nbits", 64'(cap_n[u]), 64'(pre + 32));
        chk("frame", cap_bits[u] & eo, eb & eo);
        chk("frame_oe", cap_oe[u], eo);
        chk("done_pins", 64'({mdc_o[u], mdo_valid_o[u], mdo_o[u]}), 64'd1);
        chk("ack_err", 64'({ack_o[u], err_o[u]}), (w || pres) ? 64'd2 : 64'd1);
        if (!w) chk("rdata", 64'(rd_o[u]), 64'(pres ? pd : 16'hFFFF));
        if (!keep) begin
            cyc_r[u] = 1'b0;
            stb_r[u] = 1'b0;
            tick();
            chk("pulse_cnt", 64'({8'(ack_n[u] - na), 8'(err_n[u] - ne)}),
                (w || pres) ? 64'h100 : 64'h001);
        end
    endtask

    initial begin
        int a0, na, ne;
        bit ok;
        logic [63:0] eb, eo;
        rst_r = 2'b11; cyc_r = '0; stb_r = '0; we_r = '0;
        phy_r = '0; adr_r = '0; dw_r = '0; phy_pres = '0; phy_dat = '0;
        repeat (3) tick();
        for (int u = 0; u < 2; u++)
            chk("reset_state", 64'({mdc_o[u], mdo_o[u], mdo_valid_o[u], ack_o[u], err_o[u], rd_o[u]}),
                64'({5'b01000, 16'h0}));
        rst_r = 2'b00;
        tick();

        // Directed frames on the DIV=2 / 32-bit preamble unit.
        xfer(0, 1'b1, 5'h01, 5'h04, 16'h01E1, 1'b1, 16'h0, 1'b0);
        tick();
        xfer(0, 1'b0, 5'h01, 5'h02, 16'h0, 1'b1, 16'h0141, 1'b0);
        tick();
        xfer(0, 1'b0, 5'h01, 5'h02, 16'h0, 1'b0, 16'h0, 1'b0);
        tick();

        // Reset during bit 40 of a write: no completion, clean restart.
        na = ack_n[0]; ne = err_n[0];
        we_r[0] = 1'b1; phy_r[0] = 5'h1A; adr_r[0] = 5'h11; dw_r[0] = 16'hA5C3;
        cyc_r[0] = 1'b1; stb_r[0] = 1'b1;
        tick();
        wait_bits(0, 40, ok);
        chk("rst_reach_bit40", 64'(ok), 64'd1);
        rst_r[0] = 1'b1; cyc_r[0] = 1'b0; stb_r[0] = 1'b0;
        tick();
        chk("rst_mid_pins", 64'({mdc_o[0], mdo_valid_o[0], ack_o[0], err_o[0], mdo_o[0]}), 64'd1);
        rst_r[0] = 1'b0;
        repeat (300) tick();
        chk("rst_no_done", 64'((ack_n[0] - na) + (err_n[0] - ne)), 64'd0);
        xfer(0, 1'b1, 5'h1A, 5'h11, 16'hA5C3, 1'b1, 16'h0, 1'b0);
        tick();

        // No preamble, DIV=1: read then write back-to-back with stb held.
        xfer(1, 1'b0, 5'h05, 5'h1F, 16'h0, 1'b1, 16'hBEEF, 1'b1);
        tick();
        xfer(1, 1'b1, 5'h12, 5'h03, 16'h8001, 1'b1, 16'h0, 1'b0);
        tick();

        // stb dropped after 10 bits of a read: frame completes silently.
        phy_pres[0] = 1'b1; phy_dat[0] = 16'h3C5A;
        na = ack_n[0]; ne = err_n[0];
        we_r[0] = 1'b0; phy_r[0] = 5'h03; adr_r[0] = 5'h07;
        cyc_r[0] = 1'b1; stb_r[0] = 1'b1;
        a0 = E + 1;
        tick();
        wait_bits(0, 10, ok);
        chk("drop_reach_bit10", 64'(ok), 64'd1);
        cyc_r[0] = 1'b0; stb_r[0] = 1'b0;
        for (int k = 0; k < 400 && E < a0 + 262; k++) tick();
        chk("drop_no_done", 64'((ack_n[0] - na) + (err_n[0] - ne)), 64'd0);
        chk("drop_nbits", 64'(cap_n[0]), 64'd64);
        exp_frame(32, 1'b0, 5'h03, 5'h07, 16'h0, eb, eo);
        chk("drop_frame", cap_bits[0] & eo, eb & eo);
        chk("drop_frame_oe", cap_oe[0], eo);
        xfer(0, 1'b1, 5'h03, 5'h07, 16'h1234, 1'b1, 16'h0, 1'b0);
        tick();

        // Randomised requests on both units.
        for (int i = 0; i < 6; i++) begin
            int u;
            bit w, p;
            u = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            p = ($urandom_range(0, 3) != 0);
            xfer(u, w, 5'($urandom), 5'($urandom), 16'($urandom), p, 16'($urandom), 1'b0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
